// File: rtl/ahb_slave_mux.sv
// AHB data-phase response multiplexer with a built-in default slave that answers
// unmapped active transfers with a two-cycle ERROR and counts them (saturating).
module ahb_slave_mux #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_SLV-1:0]        HSELx,
    input  logic [1:0]                HTRANS,
    input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLV-1:0]        HREADYOUT_S,
    input  logic [NUM_SLV-1:0]        HRESP_S,
    input  logic                      ERR_CLR,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [CNT_W-1:0]          ERR_CNT
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // An all-zero data-phase select means the default slave owns the data phase.
    logic [NUM_SLV-1:0] dsel_reg;
    logic               dact_reg;
    ds_state_t          state_reg;
    ds_state_t          state_next;
    logic [CNT_W-1:0]   err_cnt_reg;

    logic [NUM_SLV-1:0] asel;
    logic               sel_onehot;
    logic               asel_dflt;
    logic               trans_active;
    logic               dsel_dflt;
    logic               enter_err1;
    logic               dflt_hready;
    logic               dflt_hresp;
    logic [DATA_W-1:0]  data_masked [NUM_SLV];
    logic [DATA_W-1:0]  slv_rdata;
    logic               slv_ready;
    logic               slv_resp;

    // Zero or multiple selects both fall back to the default slave.
    assign sel_onehot   = (HSELx != '0) && ((HSELx & (HSELx - 1'b1)) == '0);
    assign asel         = sel_onehot ? HSELx : '0;
    assign asel_dflt    = !sel_onehot;
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign dsel_dflt    = (dsel_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_mask
            assign data_masked[gi] = HRDATA_S[gi*DATA_W +: DATA_W] & {DATA_W{dsel_reg[gi]}};
        end
    endgenerate

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            slv_rdata = slv_rdata | data_masked[i];
        end
        slv_ready = |(dsel_reg & HREADYOUT_S);
        slv_resp  = |(dsel_reg & HRESP_S);
    end

    assign dflt_hready = (state_reg != DS_ERR1);
    assign dflt_hresp  = dact_reg && ((state_reg == DS_ERR1) || (state_reg == DS_ERR2));

    assign HRDATA  = slv_rdata;
    assign HREADY  = dsel_dflt ? dflt_hready : slv_ready;
    assign HRESP   = dsel_dflt ? dflt_hresp  : slv_resp;
    assign ERR_CNT = err_cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DS_IDLE: if (HREADY && asel_dflt && trans_active) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = (HREADY && asel_dflt && trans_active) ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    assign enter_err1 = (state_next == DS_ERR1) && (state_reg != DS_ERR1);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_reg    <= '0;
            dact_reg    <= 1'b0;
            state_reg   <= DS_IDLE;
            err_cnt_reg <= '0;
        end else begin
            if (HREADY) begin
                dsel_reg <= asel;
                dact_reg <= trans_active;
            end
            state_reg <= state_next;
            if (ERR_CLR) begin
                err_cnt_reg <= '0;
            end else if (enter_err1 && (err_cnt_reg != {CNT_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

endmodule
